axis_rr_arbiter: RTL

Round-robin arbiter that shares one AXI4-Stream output channel between NUM_PORTS stream requesters.
- Typical requesters: AXI-Lite-to-stream writers, generators and DMA readers feeding one converter or FIFO input.
- Arbitration is packet-granular: a granted port keeps the channel until its tlast beat is accepted.
- The source port index is forwarded on m_axis_tid.

---
 rtl/axis_rr_arbiter_pkg.sv | 40 ++++
 rtl/axis_rr_arbiter_skid.sv | 75 +++++++
 rtl/axis_rr_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
// Holds the lock FSM encoding, the port-index width helper and the rotating priority pick.
package axis_rr_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int MAX_PORTS = 8;
  localparam int MAX_IDX_W = 3;

  // Bits needed to index n ports; never less than 1.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= MAX_IDX_W; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // First requester after last_grant, wrapping modulo num_ports. The search runs
  // from the farthest offset to the nearest so the nearest requester wins.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req,
                                 input int                   last_grant,
                                 input int                   num_ports);
    int                   pick;
    logic [MAX_IDX_W-1:0] idx;
    pick = last_grant;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= num_ports) begin
        idx = MAX_IDX_W'((last_grant + k) % num_ports);
        if (req[idx]) pick = int'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_skid.sv
// Two-entry AXI4-Stream skid buffer carrying tdata, tlast and tid with fully registered outputs.
// Compiled only when AXIS_RR_ARBITER_OUTREG_EN is defined.
`ifdef AXIS_RR_ARBITER_OUTREG_EN
module axis_rr_arbiter_skid #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [ID_W-1:0]   in_id_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [ID_W-1:0]   out_id_o,
  input  logic              out_ready_i
);

  localparam int PW = DATA_W + 1 + ID_W;

  logic [PW-1:0] in_pld;
  logic [PW-1:0] out_pld_q, out_pld_d;
  logic [PW-1:0] skid_pld_q, skid_pld_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          push, pop;

  assign in_pld     = {in_id_i, in_last_i, in_data_i};
  // The skid slot only fills while the output slot is stalled, so it alone means full.
  assign in_ready_o = ~skid_valid_q;
  assign push       = in_valid_i & ~skid_valid_q;
  assign pop        = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pld_d    = out_pld_q;
    skid_valid_d = skid_valid_q;
    skid_pld_d   = skid_pld_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pld_d    = skid_pld_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_pld_d = in_pld;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_pld_d   = in_pld;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid_q  <= 1'b0;
      out_pld_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pld_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pld_q    <= out_pld_d;
      skid_valid_q <= skid_valid_d;
      skid_pld_q   <= skid_pld_d;
    end
  end

  assign out_valid_o                        = out_valid_q;
  assign {out_id_o, out_last_o, out_data_o} = out_pld_q;

endmodule
`endif

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream output among NUM_PORTS sources.
// Define AXIS_RR_ARBITER_OUTREG_EN to register all m_axis outputs through a 2-entry skid buffer.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter  int AXIS_TDATA_WIDTH = 32,
  parameter  int NUM_PORTS        = 4,
  localparam int IDX_W            = idx_width(NUM_PORTS)
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
  output logic [NUM_PORTS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  output logic [IDX_W-1:0]                      m_axis_tid,
  input  logic                                  m_axis_tready,
  output state_e                                dbg_state_o
);

  localparam int W = AXIS_TDATA_WIDTH;

  // Handshake rule on every stream interface here: a beat transfers on a rising aclk
  // edge where valid & ready are both high; valid, once raised, holds its payload
  // until that transfer, and ready may depend on valid.

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      pick;
  logic [MAX_PORTS-1:0]  req_ext;
  logic                  locked;
  logic                  sel_valid;
  logic                  sel_last;
  logic [W-1:0]          sel_data;
  logic                  beat_ready;
  logic                  beat_acc;

  assign req_ext   = MAX_PORTS'(s_axis_tvalid);
  assign pick      = IDX_W'(rr_pick(req_ext, int'(last_grant_q), NUM_PORTS));
  assign locked    = (state_q == LOCKED);
  assign sel_valid = s_axis_tvalid[sel_q];
  assign sel_last  = s_axis_tlast[sel_q];
  assign sel_data  = s_axis_tdata[sel_q*W +: W];
  assign beat_acc  = locked & sel_valid & beat_ready;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          sel_d   = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (beat_acc && sel_last) begin
          last_grant_d = sel_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (locked) s_axis_tready[sel_q] = beat_ready;
  end

  assign dbg_state_o = state_q;

`ifdef AXIS_RR_ARBITER_OUTREG_EN
  logic skid_in_valid;
  logic skid_in_ready;

  // Lock releases when the tlast beat enters the buffer, not when it drains.
  assign skid_in_valid = locked & sel_valid;
  assign beat_ready    = skid_in_ready;

  axis_rr_arbiter_skid #(
    .DATA_W (W),
    .ID_W   (IDX_W)
  ) u_skid (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_valid_i  (skid_in_valid),
    .in_data_i   (sel_data),
    .in_last_i   (sel_last),
    .in_id_i     (sel_q),
    .in_ready_o  (skid_in_ready),
    .out_valid_o (m_axis_tvalid),
    .out_data_o  (m_axis_tdata),
    .out_last_o  (m_axis_tlast),
    .out_id_o    (m_axis_tid),
    .out_ready_i (m_axis_tready)
  );
`else
  assign beat_ready    = m_axis_tready;
  assign m_axis_tvalid = locked & sel_valid;
  assign m_axis_tdata  = sel_data;
  assign m_axis_tlast  = locked & sel_last;
  assign m_axis_tid    = sel_q;
`endif

endmodule
